// File: rtl/ddr4_app_responder.sv
// DDR4 MIG user-interface responder: app command/write-data intake,
// small on-chip beat store, in-order read return after a fixed latency.
module ddr4_app_responder #(
    parameter int ADDR_WIDTH   = 29,
    parameter int DATA_WIDTH   = 512,
    parameter int MEM_AW       = 6,
    parameter int CMD_DEPTH    = 4,
    parameter int WDF_DEPTH    = 4,
    parameter int RD_LATENCY   = 8,
    parameter int CALIB_CYCLES = 64,
    parameter int STALL_PERIOD = 0
) (
    input  logic                    c0_ddr4_ui_clk,
    input  logic                    c0_ddr4_aresetn,
    output logic                    c0_init_calib_complete,
    input  logic                    c0_ddr4_app_en,
    input  logic                    c0_ddr4_app_hi_pri,
    input  logic [2:0]              c0_ddr4_app_cmd,
    input  logic [ADDR_WIDTH-1:0]   c0_ddr4_app_addr,
    output logic                    c0_ddr4_app_rdy,
    input  logic                    c0_ddr4_app_wdf_wren,
    input  logic                    c0_ddr4_app_wdf_end,
    input  logic [DATA_WIDTH-1:0]   c0_ddr4_app_wdf_data,
    input  logic [DATA_WIDTH/8-1:0] c0_ddr4_app_wdf_mask,
    output logic                    c0_ddr4_app_wdf_rdy,
    output logic [DATA_WIDTH-1:0]   c0_ddr4_app_rd_data,
    output logic                    c0_ddr4_app_rd_data_valid,
    output logic                    c0_ddr4_app_rd_data_end,
    output logic                    err_cmd,
    output logic                    err_wdf
);

    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int CAW    = $clog2(CMD_DEPTH);
    localparam int WAW    = $clog2(WDF_DEPTH);
    localparam int CCW    = $clog2(CALIB_CYCLES + 1);
    localparam int PD     = RD_LATENCY - 1;
    localparam int NWORDS = 1 << MEM_AW;

    localparam logic [CAW:0] CP_ONE = 1;
    localparam logic [WAW:0] WP_ONE = 1;
    localparam logic [CCW-1:0] CC_ONE = 1;
    localparam logic [CCW-1:0] CC_END = CALIB_CYCLES;

    logic w_clk;
    logic w_rst_n;
    assign w_clk   = c0_ddr4_ui_clk;
    assign w_rst_n = c0_ddr4_aresetn;

    logic w_unused;
    assign w_unused = &{1'b0, c0_ddr4_app_hi_pri, c0_ddr4_app_addr};

    logic [CCW-1:0] r_calib_cnt;
    logic           w_calib;
    logic           w_stall;

    assign w_calib = (r_calib_cnt == CC_END);

    // Calibration counter: saturates at CALIB_CYCLES, restarts on reset.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n)
            r_calib_cnt <= '0;
        else if (!w_calib)
            r_calib_cnt <= r_calib_cnt + CC_ONE;
    end

    if (STALL_PERIOD > 0) begin : g_stall
        localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
        localparam logic [SW-1:0] S_END = SW'(STALL_PERIOD - 1);
        localparam logic [SW-1:0] S_ONE = 1;
        logic [SW-1:0] r_stall_cnt;

        // Free-running stall phase counter.
        always_ff @(posedge w_clk or negedge w_rst_n) begin
            if (!w_rst_n)
                r_stall_cnt <= '0;
            else if (r_stall_cnt == S_END)
                r_stall_cnt <= '0;
            else
                r_stall_cnt <= r_stall_cnt + S_ONE;
        end

        assign w_stall = (r_stall_cnt == S_END);
    end else begin : g_nostall
        assign w_stall = 1'b0;
    end

    logic                r_cmd_rd  [CMD_DEPTH];
    logic [MEM_AW-1:0]   r_cmd_idx [CMD_DEPTH];
    logic [CAW:0]        r_cmd_wp;
    logic [CAW:0]        r_cmd_rp;
    logic                w_cmd_full;
    logic                w_cmd_empty;
    logic                w_cmd_legal;
    logic                w_cmd_acc;
    logic                w_cmd_push;
    logic                w_cmd_pop;
    logic                w_app_rdy;
    logic                w_head_rd;
    logic [MEM_AW-1:0]   w_head_idx;
    logic [MEM_AW-1:0]   w_new_idx;

    assign w_cmd_empty = (r_cmd_wp == r_cmd_rp);
    assign w_cmd_full  = (r_cmd_wp[CAW] != r_cmd_rp[CAW]) &&
                         (r_cmd_wp[CAW-1:0] == r_cmd_rp[CAW-1:0]);
    assign w_cmd_legal = (c0_ddr4_app_cmd == 3'b000) ||
                         (c0_ddr4_app_cmd == 3'b001);
    assign w_app_rdy   = w_calib & ~w_cmd_full & ~w_stall;
    assign w_cmd_acc   = c0_ddr4_app_en & w_app_rdy;
    assign w_cmd_push  = w_cmd_acc & w_cmd_legal;
    assign w_new_idx   = c0_ddr4_app_addr[3 +: MEM_AW];
    assign w_head_rd   = r_cmd_rd[r_cmd_rp[CAW-1:0]];
    assign w_head_idx  = r_cmd_idx[r_cmd_rp[CAW-1:0]];

    // Command queue storage: read flag plus beat index.
    always_ff @(posedge w_clk) begin
        if (w_cmd_push) begin
            r_cmd_rd[r_cmd_wp[CAW-1:0]]  <= c0_ddr4_app_cmd[0];
            r_cmd_idx[r_cmd_wp[CAW-1:0]] <= w_new_idx;
        end
    end

    // Command queue pointers.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cmd_wp <= '0;
            r_cmd_rp <= '0;
        end else begin
            if (w_cmd_push)
                r_cmd_wp <= r_cmd_wp + CP_ONE;
            if (w_cmd_pop)
                r_cmd_rp <= r_cmd_rp + CP_ONE;
        end
    end

    logic [DATA_WIDTH-1:0] r_wdf_data [WDF_DEPTH];
    logic [MASK_W-1:0]     r_wdf_mask [WDF_DEPTH];
    logic [WAW:0]          r_wdf_wp;
    logic [WAW:0]          r_wdf_rp;
    logic                  w_wdf_full;
    logic                  w_wdf_empty;
    logic                  w_wdf_rdy;
    logic                  w_wdf_push;
    logic                  w_wdf_pop;
    logic [DATA_WIDTH-1:0] w_wdf_hdata;
    logic [MASK_W-1:0]     w_wdf_hmask;

    assign w_wdf_empty = (r_wdf_wp == r_wdf_rp);
    assign w_wdf_full  = (r_wdf_wp[WAW] != r_wdf_rp[WAW]) &&
                         (r_wdf_wp[WAW-1:0] == r_wdf_rp[WAW-1:0]);
    assign w_wdf_rdy   = w_calib & ~w_wdf_full;
    assign w_wdf_push  = c0_ddr4_app_wdf_wren & w_wdf_rdy;
    assign w_wdf_hdata = r_wdf_data[r_wdf_rp[WAW-1:0]];
    assign w_wdf_hmask = r_wdf_mask[r_wdf_rp[WAW-1:0]];

    // Write-data queue storage.
    always_ff @(posedge w_clk) begin
        if (w_wdf_push) begin
            r_wdf_data[r_wdf_wp[WAW-1:0]] <= c0_ddr4_app_wdf_data;
            r_wdf_mask[r_wdf_wp[WAW-1:0]] <= c0_ddr4_app_wdf_mask;
        end
    end

    // Write-data queue pointers.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wdf_wp <= '0;
            r_wdf_rp <= '0;
        end else begin
            if (w_wdf_push)
                r_wdf_wp <= r_wdf_wp + WP_ONE;
            if (w_wdf_pop)
                r_wdf_rp <= r_wdf_rp + WP_ONE;
        end
    end

    // Executor: a write head stalls until its data beat is queued.
    logic                  w_rd_issue;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic [DATA_WIDTH-1:0] r_mem [NWORDS];

    assign w_rd_issue  = ~w_cmd_empty & w_head_rd;
    assign w_wdf_pop   = ~w_cmd_empty & ~w_head_rd & ~w_wdf_empty;
    assign w_cmd_pop   = w_rd_issue | w_wdf_pop;
    assign w_mem_rdata = r_mem[w_head_idx];

    // Byte-masked array write; contents survive reset.
    always_ff @(posedge w_clk) begin
        if (w_wdf_pop) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!w_wdf_hmask[b])
                    r_mem[w_head_idx][8*b +: 8] <= w_wdf_hdata[8*b +: 8];
            end
        end
    end

    logic [PD-1:0]         r_pv;
    logic [DATA_WIDTH-1:0] r_pd [PD];
    logic                  r_rd_vld;
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Read delay line; last stage is the output register below.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pv <= '0;
            for (int i = 0; i < PD; i++)
                r_pd[i] <= '0;
        end else begin
            r_pv[0] <= w_rd_issue;
            r_pd[0] <= w_mem_rdata;
            for (int i = 1; i < PD; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    // Output stage: data holds its last value between beats.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_vld <= r_pv[PD-1];
            if (r_pv[PD-1])
                r_rd_data <= r_pd[PD-1];
        end
    end

    logic r_err_cmd;
    logic r_err_wdf;

    // Sticky protocol error flags.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_err_cmd <= 1'b0;
            r_err_wdf <= 1'b0;
        end else begin
            if (w_cmd_acc && !w_cmd_legal)
                r_err_cmd <= 1'b1;
            if (w_wdf_push && !c0_ddr4_app_wdf_end)
                r_err_wdf <= 1'b1;
        end
    end

    assign c0_init_calib_complete    = w_calib;
    assign c0_ddr4_app_rdy           = w_app_rdy;
    assign c0_ddr4_app_wdf_rdy       = w_wdf_rdy;
    assign c0_ddr4_app_rd_data       = r_rd_data;
    assign c0_ddr4_app_rd_data_valid = r_rd_vld;
    assign c0_ddr4_app_rd_data_end   = r_rd_vld;
    assign err_cmd                   = r_err_cmd;
    assign err_wdf                   = r_err_wdf;

endmodule

// File: tb/tb_ddr4_app_responder.sv
// Directed bench for ddr4_app_responder: calibration, ordering,
// masking, queue backpressure, stall pattern, errors and reset abort.
module tb_ddr4_app_responder;

    localparam int AW = 29;
    localparam int DW = 512;
    localparam int MW = DW / 8;
    localparam int L  = 8;
    localparam int DW2 = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          calib;
    logic          app_en;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic          app_rdy;
    logic          wren;
    logic          wend;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic          wdf_rdy;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_end;
    logic          e_cmd;
    logic          e_wdf;

    logic           rst2_n;
    logic           calib2;
    logic           en2;
    logic [2:0]     cmd2;
    logic [AW-1:0]  addr2;
    logic           rdy2;
    logic           wren2;
    logic [DW2-1:0] wdata2;
    logic           wrdy2;
    logic [DW2-1:0] rd2;
    logic           rdv2;
    logic           rde2;
    logic           ec2;
    logic           ew2;

    ddr4_app_responder u_dut (
        .c0_ddr4_ui_clk            (clk),
        .c0_ddr4_aresetn           (rst_n),
        .c0_init_calib_complete    (calib),
        .c0_ddr4_app_en            (app_en),
        .c0_ddr4_app_hi_pri        (1'b0),
        .c0_ddr4_app_cmd           (app_cmd),
        .c0_ddr4_app_addr          (app_addr),
        .c0_ddr4_app_rdy           (app_rdy),
        .c0_ddr4_app_wdf_wren      (wren),
        .c0_ddr4_app_wdf_end       (wend),
        .c0_ddr4_app_wdf_data      (wdata),
        .c0_ddr4_app_wdf_mask      (wmask),
        .c0_ddr4_app_wdf_rdy       (wdf_rdy),
        .c0_ddr4_app_rd_data       (rd_data),
        .c0_ddr4_app_rd_data_valid (rd_valid),
        .c0_ddr4_app_rd_data_end   (rd_end),
        .err_cmd                   (e_cmd),
        .err_wdf                   (e_wdf)
    );

    ddr4_app_responder #(
        .DATA_WIDTH   (DW2),
        .CALIB_CYCLES (4),
        .STALL_PERIOD (4)
    ) u_dut2 (
        .c0_ddr4_ui_clk            (clk),
        .c0_ddr4_aresetn           (rst2_n),
        .c0_init_calib_complete    (calib2),
        .c0_ddr4_app_en            (en2),
        .c0_ddr4_app_hi_pri        (1'b0),
        .c0_ddr4_app_cmd           (cmd2),
        .c0_ddr4_app_addr          (addr2),
        .c0_ddr4_app_rdy           (rdy2),
        .c0_ddr4_app_wdf_wren      (wren2),
        .c0_ddr4_app_wdf_end       (1'b1),
        .c0_ddr4_app_wdf_data      (wdata2),
        .c0_ddr4_app_wdf_mask      (4'h0),
        .c0_ddr4_app_wdf_rdy       (wrdy2),
        .c0_ddr4_app_rd_data       (rd2),
        .c0_ddr4_app_rd_data_valid (rdv2),
        .c0_ddr4_app_rd_data_end   (rde2),
        .err_cmd                   (ec2),
        .err_wdf                   (ew2)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [DW-1:0]  rq [$];
    int             rqc [$];
    logic [DW2-1:0] q2 [$];

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Read-beat collectors, sampled on the falling edge.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            rq.push_back(rd_data);
            rqc.push_back(cyc);
            chk("rd_end", {511'd0, rd_end}, 1);
        end
        if (rdv2 === 1'b1) begin
            q2.push_back(rd2);
            chk("rd_end2", {511'd0, rde2}, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a);
        int t;
        logic acc;
        t = 0;
        app_en = 1'b1;
        app_cmd = c;
        app_addr = a;
        do begin
            acc = app_rdy;
            tick();
            t++;
        end while (!acc && t < 200);
        app_en = 1'b0;
        chk("cmd_accept", {511'd0, acc}, 1);
    endtask

    task automatic send_wdf(input logic [DW-1:0] d, input logic [MW-1:0] m,
                            input logic e);
        int t;
        logic acc;
        t = 0;
        wren = 1'b1;
        wdata = d;
        wmask = m;
        wend = e;
        do begin
            acc = wdf_rdy;
            tick();
            t++;
        end while (!acc && t < 200);
        wren = 1'b0;
        wend = 1'b1;
        chk("wdf_accept", {511'd0, acc}, 1);
    endtask

    task automatic write_both(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [MW-1:0] m);
        int t;
        logic acc;
        t = 0;
        app_en = 1'b1;
        app_cmd = 3'b000;
        app_addr = a;
        wren = 1'b1;
        wdata = d;
        wmask = m;
        wend = 1'b1;
        do begin
            acc = app_rdy && wdf_rdy;
            tick();
            t++;
        end while (!acc && t < 200);
        app_en = 1'b0;
        wren = 1'b0;
        chk("wr_accept", {511'd0, acc}, 1);
    endtask

    initial begin
        int e0;
        int c;
        int d;
        int n;
        logic acc_c;
        logic acc_d;
        logic exp_rdy;

        rst_n = 1'b0;
        rst2_n = 1'b0;
        app_en = 1'b0;
        app_cmd = 3'b000;
        app_addr = '0;
        wren = 1'b0;
        wend = 1'b1;
        wdata = '0;
        wmask = '0;
        en2 = 1'b0;
        cmd2 = 3'b000;
        addr2 = '0;
        wren2 = 1'b0;
        wdata2 = '0;

        // Reset state and calibration timing.
        repeat (3) tick();
        chk("rst_calib", {511'd0, calib}, 0);
        chk("rst_app_rdy", {511'd0, app_rdy}, 0);
        chk("rst_wdf_rdy", {511'd0, wdf_rdy}, 0);
        chk("rst_rd_valid", {511'd0, rd_valid}, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_errs", {510'd0, e_cmd, e_wdf}, 0);
        rst_n = 1'b1;
        cyc = 0;
        repeat (63) tick();
        chk("calib_63", {511'd0, calib}, 0);
        chk("app_rdy_63", {511'd0, app_rdy}, 0);
        chk("wdf_rdy_63", {511'd0, wdf_rdy}, 0);
        tick();
        chk("calib_64", {511'd0, calib}, 1);
        chk("app_rdy_64", {511'd0, app_rdy}, 1);
        chk("wdf_rdy_64", {511'd0, wdf_rdy}, 1);
        repeat (36) tick();
        chk("calib_100", {511'd0, calib}, 1);

        // Sixteen writes then sixteen back-to-back reads.
        for (int i = 0; i < 16; i++)
            write_both(AW'(i * 8), DW'(i), '0);
        repeat (4) tick();
        rq.delete();
        rqc.delete();
        e0 = 0;
        for (int i = 0; i < 16; i++) begin
            send_cmd(3'b001, AW'(i * 8));
            if (i == 0)
                e0 = cyc;
        end
        repeat (L + 4) tick();
        chk("seq_count", DW'(rq.size()), 16);
        if (rq.size() == 16) begin
            for (int i = 0; i < 16; i++)
                chk($sformatf("seq_data%0d", i), rq[i], DW'(i));
            chk("seq_first_lat", DW'(rqc[0]), DW'(e0 + L));
            chk("seq_last_lat", DW'(rqc[15]), DW'(e0 + L + 15));
        end

        // Byte mask: only byte 0 overwritten.
        write_both(AW'(8), '1, '0);
        write_both(AW'(8), '0, 64'hFFFF_FFFF_FFFF_FFFE);
        repeat (2) tick();
        rq.delete();
        rqc.delete();
        send_cmd(3'b001, AW'(8));
        repeat (L + 3) tick();
        chk("mask_count", DW'(rq.size()), 1);
        if (rq.size() == 1)
            chk("mask_data", rq[0], ~DW'(8'hFF));

        // Write command ahead of its data; read ordering; queue full.
        rq.delete();
        rqc.delete();
        send_cmd(3'b000, AW'('h10));
        send_cmd(3'b001, AW'('h10));
        send_cmd(3'b001, AW'('h08));
        send_cmd(3'b001, AW'('h00));
        chk("full_app_rdy", {511'd0, app_rdy}, 0);
        chk("full_wdf_rdy", {511'd0, wdf_rdy}, 1);
        tick();
        chk("early_no_read", DW'(rq.size()), 0);
        send_wdf(DW'(8'hA5), '0, 1'b1);
        repeat (L + 6) tick();
        chk("ord_count", DW'(rq.size()), 3);
        if (rq.size() == 3) begin
            chk("ord_data0", rq[0], DW'(8'hA5));
            chk("ord_data1", rq[1], ~DW'(8'hFF));
            chk("ord_data2", rq[2], 0);
        end
        chk("drain_app_rdy", {511'd0, app_rdy}, 1);

        // Illegal command, missing wdf_end, then reset aborts reads.
        rq.delete();
        rqc.delete();
        send_cmd(3'b010, '0);
        chk("err_cmd_set", {511'd0, e_cmd}, 1);
        chk("err_wdf_clear", {511'd0, e_wdf}, 0);
        repeat (L + 2) tick();
        chk("err_cmd_sticky", {511'd0, e_cmd}, 1);
        chk("illegal_no_read", DW'(rq.size()), 0);
        send_wdf(DW'(8'h77), '0, 1'b0);
        chk("err_wdf_set", {511'd0, e_wdf}, 1);
        send_cmd(3'b001, '0);
        send_cmd(3'b001, AW'(8));
        send_cmd(3'b001, AW'('h10));
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_calib", {511'd0, calib}, 0);
        chk("arst_app_rdy", {511'd0, app_rdy}, 0);
        chk("arst_errs", {510'd0, e_cmd, e_wdf}, 0);
        chk("arst_rd_valid", {511'd0, rd_valid}, 0);
        chk("arst_rd_data", rd_data, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (L + 10) tick();
        chk("abort_no_read", DW'(rq.size()), 0);
        chk("recal_pending", {511'd0, calib}, 0);

        // Periodic stall on a second instance with continuous app_en.
        tick();
        rst2_n = 1'b1;
        c = 0;
        d = 0;
        n = 0;
        while (c < 16 && n < 100) begin
            en2 = 1'b1;
            cmd2 = (c < 8) ? 3'b000 : 3'b001;
            addr2 = AW'((c % 8) * 8);
            wren2 = (d < 8);
            wdata2 = DW2'(32'h100 + d);
            exp_rdy = (n >= 4) && (n % 4 != 3);
            chk($sformatf("stall_rdy_n%0d", n), {511'd0, rdy2},
                {511'd0, exp_rdy});
            acc_c = rdy2;
            acc_d = wren2 && wrdy2;
            tick();
            n++;
            if (acc_c)
                c++;
            if (acc_d)
                d++;
        end
        en2 = 1'b0;
        wren2 = 1'b0;
        chk("stall_cmds", DW'(c), 16);
        repeat (L + 6) tick();
        chk("stall_beats", DW'(q2.size()), 8);
        if (q2.size() == 8) begin
            for (int k = 0; k < 8; k++)
                chk($sformatf("stall_data%0d", k), DW'(q2[k]),
                    DW'(32'h100 + k));
        end
        chk("stall_errs", {510'd0, ec2, ew2}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
